sobel_window_fetch: RTL and testbench
=====================================

SOBEL_WINDOW_FETCH -- requirements
Module: sobel_window_fetch

Interface
REQ-001 SHALL have parameter IMG_DIM, default 128, meaning image width and height in pixels (square image).
REQ-002 SHALL have parameter PX_W, default 8, meaning pixel width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: fetch request, sampled only while idle.
REQ-006 SHALL have ports px_x and px_y, input, 7 bits each: centre pixel column and row.
REQ-007 SHALL have port rom_addr, output, 14 bits: image ROM read address {row[6:0], col[6:0]}.
REQ-008 SHALL have port rom_data, input, 8 bits: ROM read data, valid exactly one cycle after rom_addr is clocked into the ROM.
REQ-009 SHALL have port busy, output, 1 bit: high while a fetch is in progress.
REQ-010 SHALL have port win_valid, output, 1 bit: single-cycle pulse marking the window complete.
REQ-011 SHALL have port window, output, 72 bits: taps p0..p8, with pk on bits [8k+7:8k].

Function
REQ-012 SHALL implement the states IDLE, FETCH and DRAIN.
REQ-013 IDLE with start=1 at edge E0 SHALL latch px_x/px_y, set the tap index to 0 and move to FETCH.
REQ-014 SHALL order the taps row-major: p0=(y-1,x-1), p1=(y-1,x), p2=(y-1,x+1), p3=(y,x-1), p4=(y,x), p5=(y,x+1), p6=(y+1,x-1), p7=(y+1,x), p8=(y+1,x+1).
REQ-015 In FETCH, rom_addr SHALL combinationally present the address of tap k, and the tap index SHALL increment each clock.
REQ-016 After the edge that presents tap 8 (E9), the block SHALL move to DRAIN.
REQ-017 Each rom_data value SHALL be captured into slot k on the edge after tap k's address is clocked into the ROM; the capture uses a pipelined index and out-of-bounds flag.
REQ-018 At E10 the block SHALL capture p8, pulse win_valid high for exactly one cycle and return to IDLE.
REQ-019 Latency from the start-sampling edge to win_valid high SHALL be exactly 10 clocks, independent of coordinates.
REQ-020 Out-of-bounds taps (coordinate -1 or IMG_DIM) SHALL drive rom_addr=0 and store 0; there is no wrap-around and timing is unchanged.
REQ-021 busy SHALL be high in FETCH and DRAIN and low in IDLE, including during the win_valid cycle.
REQ-022 start asserted while busy=1 SHALL be ignored.
REQ-023 start asserted during the win_valid cycle SHALL be accepted, allowing back-to-back windows every 10 clocks.
REQ-024 window SHALL hold its last completed value until the next win_valid.
REQ-025 Taps of a fetch in progress SHALL update only internal slots, never the window output.
REQ-026 px_x/px_y changes after E0 SHALL NOT affect the fetch in progress.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, with busy=0, win_valid=0, window=0, rom_addr=0 and tap index=0.
REQ-028 Reset during FETCH or DRAIN SHALL abort the fetch with no win_valid pulse; the first start after reset release SHALL behave as from power-up.

Structure
REQ-029 A shared package SHALL hold IMG_DIM, PX_W, ADDR_W=14, TAPS=9 and the state encoding; the Sobel control unit and datapath SHALL use the same package.
REQ-030 Tap-to-address/out-of-bounds generation SHALL be one combinational sub-module, sobel_tap_addr_gen (inputs: centre and tap index; outputs: address and oob flag).
REQ-031 The ROM SHALL be external to this block.

Verification
REQ-032 The bench SHALL use a one-cycle-latency ROM model returning (col + 2*row + 1) mod 256.
REQ-033 Interior, start with x=5, y=5 -> win_valid 10 clocks later; p0=13, p4=16, p8=19; busy high for exactly 10 cycles.
REQ-034 Corner, x=0, y=0 -> p0=p1=p2=p3=p6=0; p4=1, p5=2, p7=3, p8=4.
REQ-035 Corner, x=127, y=127 -> p2=p5=p6=p7=p8=0; p0=123, p4=126.
REQ-036 start pulses at cycles 3-6 during a fetch are ignored -> exactly one win_valid; start in the win_valid cycle with x=6, y=5 -> second win_valid 10 clocks later with p4=17.
REQ-037 rst asserted at the 5th FETCH cycle -> outputs 0 at once, no win_valid; a new start with x=5, y=5 yields REQ-033 results.
REQ-038 px_x changed from 5 to 100 at E3 -> window still matches x=5, y=5.

Source files
------------

// File: rtl/sobel_window_fetch_pkg.sv
// Shared constants and state encoding for the Sobel 3x3 window fetcher.
// Used by the control unit, the datapath and the tap address generator so
// that image geometry and state encodings live in exactly one place.
package sobel_window_fetch_pkg;

  localparam int IMG_DIM = 128;  // square image edge in pixels
  localparam int PX_W    = 8;    // pixel width in bits
  localparam int COORD_W = 7;    // column/row coordinate width
  localparam int ADDR_W  = 14;   // ROM address {row, col}
  localparam int TAPS    = 9;    // 3x3 window
  localparam int IDX_W   = 4;    // tap index width (0..8)

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sobel_tap_addr_gen.sv
// Combinational tap-to-address generator for the 3x3 Sobel window.
// Tap k maps to row offset k/3-1 and column offset k%3-1 around the centre.
// A tap whose row or column falls at -1 or IMG_DIM is flagged out of bounds
// and its address forced to 0, so there is never any wrap-around.
//
// Ports:
//   i_cx, i_cy   centre column / row
//   i_tap_idx    tap index 0..8 (row-major)
//   o_addr       ROM address {row, col}, 0 when out of bounds
//   o_oob        tap lies outside the image
module sobel_tap_addr_gen
  import sobel_window_fetch_pkg::*;
#(
  parameter int IMG_DIM = sobel_window_fetch_pkg::IMG_DIM
) (
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  input  logic [IDX_W-1:0]   i_tap_idx,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_oob
);

  // Coordinates are carried as (coord + 1) in one extra bit, so -1 becomes 0
  // and IMG_DIM becomes IMG_DIM+1; both are easy equality tests.
  localparam logic [COORD_W:0] EDGE_P1 = (COORD_W+1)'(IMG_DIM + 1);

  logic [1:0]         w_dr;
  logic [1:0]         w_dc;
  logic [COORD_W:0]   w_row_p1;
  logic [COORD_W:0]   w_col_p1;
  logic [COORD_W-1:0] w_row;
  logic [COORD_W-1:0] w_col;
  logic               w_row_oob;
  logic               w_col_oob;

  always_comb begin
    w_dr = 2'd1;
    w_dc = 2'd1;
    case (i_tap_idx)
      4'd0: begin w_dr = 2'd0; w_dc = 2'd0; end
      4'd1: begin w_dr = 2'd0; w_dc = 2'd1; end
      4'd2: begin w_dr = 2'd0; w_dc = 2'd2; end
      4'd3: begin w_dr = 2'd1; w_dc = 2'd0; end
      4'd4: begin w_dr = 2'd1; w_dc = 2'd1; end
      4'd5: begin w_dr = 2'd1; w_dc = 2'd2; end
      4'd6: begin w_dr = 2'd2; w_dc = 2'd0; end
      4'd7: begin w_dr = 2'd2; w_dc = 2'd1; end
      4'd8: begin w_dr = 2'd2; w_dc = 2'd2; end
      default: begin w_dr = 2'd1; w_dc = 2'd1; end
    endcase
  end

  assign w_row_p1 = {1'b0, i_cy} + {{(COORD_W-1){1'b0}}, w_dr};
  assign w_col_p1 = {1'b0, i_cx} + {{(COORD_W-1){1'b0}}, w_dc};

  assign w_row_oob = (w_row_p1 == '0) || (w_row_p1 == EDGE_P1);
  assign w_col_oob = (w_col_p1 == '0) || (w_col_p1 == EDGE_P1);

  assign w_row = w_row_p1[COORD_W-1:0] - COORD_W'(1);
  assign w_col = w_col_p1[COORD_W-1:0] - COORD_W'(1);

  assign o_oob  = w_row_oob || w_col_oob;
  assign o_addr = o_oob ? '0 : {w_row, w_col};

endmodule

// File: rtl/sobel_window_fetch.sv
// Sobel 3x3 window fetcher. On start (while idle) it latches the centre
// pixel, walks the nine taps row-major through an external one-cycle-latency
// ROM, and publishes the assembled window with a single-cycle win_valid
// pulse exactly 10 clocks after start was sampled.
//
// State table:
//   state   | meaning
//   S_IDLE  | waiting for start; window holds last result
//   S_FETCH | presenting tap addresses 0..8, one per clock
//   S_DRAIN | last ROM read in flight; p8 captured on exit
//
// Ports:
//   clk, rst          clock, async active-high reset
//   start             fetch request, sampled only in S_IDLE
//   px_x, px_y        centre column / row
//   rom_addr          ROM address {row, col}, 0 when idle or out of bounds
//   rom_data          ROM data, one cycle after the address is clocked in
//   busy              high in S_FETCH and S_DRAIN
//   win_valid         one-cycle pulse when window updates
//   window            p0..p8, pk on bits [8k+7:8k]
module sobel_window_fetch
  import sobel_window_fetch_pkg::*;
#(
  parameter int IMG_DIM = sobel_window_fetch_pkg::IMG_DIM,
  parameter int PX_W    = sobel_window_fetch_pkg::PX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [COORD_W-1:0]   px_x,
  input  logic [COORD_W-1:0]   px_y,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [PX_W-1:0]      rom_data,
  output logic                 busy,
  output logic                 win_valid,
  output logic [TAPS*PX_W-1:0] window
);

  state_t r_state;
  state_t w_next;

  logic [COORD_W-1:0] r_cx;
  logic [COORD_W-1:0] r_cy;
  logic [IDX_W-1:0]   r_tap_idx;

  // Capture pipeline: index/oob of the address the ROM saw last edge.
  logic               r_cap_en;
  logic [IDX_W-1:0]   r_cap_idx;
  logic               r_cap_oob;

  // p0..p7; p8 goes straight into the window on the final capture.
  logic [TAPS-2:0][PX_W-1:0] r_slot;
  logic [TAPS*PX_W-1:0]      r_window;
  logic                      r_win_valid;

  logic [ADDR_W-1:0] w_tap_addr;
  logic              w_tap_oob;
  logic              w_accept;
  logic              w_last_tap;
  logic [PX_W-1:0]   w_cap_px;

  sobel_tap_addr_gen #(
    .IMG_DIM (IMG_DIM)
  ) u_tap_addr_gen (
    .i_cx      (r_cx),
    .i_cy      (r_cy),
    .i_tap_idx (r_tap_idx),
    .o_addr    (w_tap_addr),
    .o_oob     (w_tap_oob)
  );

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last_tap = (r_tap_idx == IDX_W'(TAPS - 1));
  assign w_cap_px   = r_cap_oob ? '0 : rom_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (w_last_tap) w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (r_state != S_IDLE);
    rom_addr = (r_state == S_FETCH) ? w_tap_addr : '0;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cx        <= '0;
      r_cy        <= '0;
      r_tap_idx   <= '0;
      r_cap_en    <= 1'b0;
      r_cap_idx   <= '0;
      r_cap_oob   <= 1'b0;
      r_slot      <= '0;
      r_window    <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      r_cap_en    <= (r_state == S_FETCH);
      r_cap_idx   <= r_tap_idx;
      r_cap_oob   <= w_tap_oob;

      if (w_accept) begin
        r_cx      <= px_x;
        r_cy      <= px_y;
        r_tap_idx <= '0;
      end else if (r_state == S_FETCH) begin
        r_tap_idx <= w_last_tap ? '0 : r_tap_idx + IDX_W'(1);
      end

      if (r_cap_en) begin
        if (r_cap_idx == IDX_W'(TAPS - 1)) begin
          r_window    <= {w_cap_px, r_slot};
          r_win_valid <= 1'b1;
        end else begin
          r_slot[r_cap_idx[2:0]] <= w_cap_px;
        end
      end
    end
  end

  assign window    = r_window;
  assign win_valid = r_win_valid;

endmodule

// File: tb/tb_sobel_window_fetch.sv
module tb_sobel_window_fetch;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  px_x;
  logic [6:0]  px_y;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic        busy;
  logic        win_valid;
  logic [71:0] window;

  int checks;
  int errors;

  sobel_window_fetch #(
    .IMG_DIM (128),
    .PX_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .px_x      (px_x),
    .px_y      (px_y),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .win_valid (win_valid),
    .window    (window)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency ROM: (col + 2*row + 1) mod 256
  always @(posedge clk)
    rom_data <= 8'(int'(rom_addr[6:0]) + 2 * int'(rom_addr[13:7]) + 1);

  function automatic logic [71:0] model_win(input int x, input int y);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      int r;
      int c;
      r = y + k / 3 - 1;
      c = x + k % 3 - 1;
      if (r >= 0 && r < 128 && c >= 0 && c < 128)
        w[8*k +: 8] = 8'(c + 2 * r + 1);
    end
    return w;
  endfunction

  // Stimulus only: issue a start at the current cycle, then wait (bounded)
  // for win_valid. Called and returns at posedge+1.
  task automatic fetch(input int x, input int y, output int lat,
                       output int busy_cycles, output logic [13:0] addr0);
    start = 1'b1;
    px_x  = 7'(x);
    px_y  = 7'(y);
    @(posedge clk); #1;
    start = 1'b0;
    addr0 = rom_addr;
    busy_cycles = busy ? 1 : 0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busy) busy_cycles++;
      if (win_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    px_x = '0;
    px_y = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0 || window !== 72'd0 || rom_addr !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b wv=%b window=%h addr=%h want 0/0/0/0",
               busy, win_valid, window, rom_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rom_addr !== 14'd0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b addr=%h want 0/0", busy, rom_addr);
    end
  endtask

  task automatic test_interior();
    int lat, bc;
    logic [13:0] a0;
    logic [71:0] w;
    fetch(5, 5, lat, bc, a0);
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL interior_latency got %0d want 10", lat); end
    checks++;
    if (bc !== 10) begin errors++; $display("FAIL interior_busy_cycles got %0d want 10", bc); end
    checks++;
    if (a0 !== {7'd4, 7'd4}) begin errors++; $display("FAIL interior_first_addr got %h want %h", a0, {7'd4, 7'd4}); end
    checks++;
    if (window[7:0] !== 8'd13 || window[39:32] !== 8'd16 || window[71:64] !== 8'd19) begin
      errors++;
      $display("FAIL interior_p0_p4_p8 got %0d %0d %0d want 13 16 19",
               window[7:0], window[39:32], window[71:64]);
    end
    checks++;
    if (window !== model_win(5, 5)) begin
      errors++;
      $display("FAIL interior_window got %h want %h", window, model_win(5, 5));
    end
    w = window;
    @(posedge clk); #1;
    checks++;
    if (win_valid !== 1'b0) begin errors++; $display("FAIL win_valid_pulse_width got %b want 0", win_valid); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (window !== w) begin errors++; $display("FAIL window_hold got %h want %h", window, w); end
  endtask

  task automatic test_corner_lo();
    int lat, bc;
    logic [13:0] a0;
    fetch(0, 0, lat, bc, a0);
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL corner_lo_latency got %0d want 10", lat); end
    checks++;
    if (a0 !== 14'd0) begin errors++; $display("FAIL corner_lo_oob_addr got %h want 0", a0); end
    checks++;
    if (window[7:0] !== 8'd0 || window[15:8] !== 8'd0 || window[23:16] !== 8'd0 ||
        window[31:24] !== 8'd0 || window[55:48] !== 8'd0) begin
      errors++;
      $display("FAIL corner_lo_oob_taps got %h want p0 p1 p2 p3 p6 zero", window);
    end
    checks++;
    if (window[39:32] !== 8'd1 || window[47:40] !== 8'd2 || window[63:56] !== 8'd3 || window[71:64] !== 8'd4) begin
      errors++;
      $display("FAIL corner_lo_inner_taps got %0d %0d %0d %0d want 1 2 3 4",
               window[39:32], window[47:40], window[63:56], window[71:64]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_corner_hi();
    int lat, bc;
    logic [13:0] a0;
    fetch(127, 127, lat, bc, a0);
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL corner_hi_latency got %0d want 10", lat); end
    checks++;
    if (window[7:0] !== 8'd123 || window[39:32] !== 8'd126) begin
      errors++;
      $display("FAIL corner_hi_p0_p4 got %0d %0d want 123 126", window[7:0], window[39:32]);
    end
    checks++;
    if (window !== model_win(127, 127)) begin
      errors++;
      $display("FAIL corner_hi_window got %h want %h", window, model_win(127, 127));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int wins;
    int lat;
    logic [71:0] prev;
    start = 1'b1;
    px_x = 7'd5;
    px_y = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wins = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (win_valid) wins++;
      start = (n >= 2 && n <= 5);
      px_x  = start ? 7'd50 : 7'd5;
    end
    checks++;
    if (wins !== 1 || win_valid !== 1'b1) begin
      errors++;
      $display("FAIL ignored_start_wins got %0d (wv=%b) want 1 at cycle 10", wins, win_valid);
    end
    checks++;
    if (window !== model_win(5, 5)) begin
      errors++;
      $display("FAIL ignored_start_window got %h want %h", window, model_win(5, 5));
    end
    prev = window;
    start = 1'b1;
    px_x = 7'd6;
    px_y = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    wins = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin
        checks++;
        if (window !== prev) begin
          errors++;
          $display("FAIL window_stable_during_fetch got %h want %h", window, prev);
        end
      end
      if (win_valid) begin
        wins++;
        if (lat < 0) lat = n;
        checks++;
        if (window[39:32] !== 8'd17 || window !== model_win(6, 5)) begin
          errors++;
          $display("FAIL b2b_window got %h want %h", window, model_win(6, 5));
        end
      end
    end
    checks++;
    if (lat !== 10 || wins !== 1) begin
      errors++;
      $display("FAIL b2b_latency got lat=%0d wins=%0d want 10/1", lat, wins);
    end
  endtask

  task automatic test_reset_abort();
    int wins, lat, bc;
    logic [13:0] a0;
    start = 1'b1;
    px_x = 7'd5;
    px_y = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0 || window !== 72'd0 || rom_addr !== 14'd0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b wv=%b window=%h addr=%h want 0/0/0/0",
               busy, win_valid, window, rom_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wins = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (win_valid || busy) wins++;
    end
    checks++;
    if (wins !== 0) begin errors++; $display("FAIL abort_no_win_valid got %0d active cycles want 0", wins); end
    fetch(5, 5, lat, bc, a0);
    checks++;
    if (lat !== 10 || bc !== 10 || window !== model_win(5, 5)) begin
      errors++;
      $display("FAIL after_abort_fetch got lat=%0d busy=%0d window=%h want 10/10/%h",
               lat, bc, window, model_win(5, 5));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_px_change();
    int lat;
    start = 1'b1;
    px_x = 7'd5;
    px_y = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (n == 2) px_x = 7'd100;
      if (win_valid && lat < 0) lat = n;
    end
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL px_change_latency got %0d want 10", lat); end
    checks++;
    if (window !== model_win(5, 5)) begin
      errors++;
      $display("FAIL px_change_window got %h want %h", window, model_win(5, 5));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_interior();
    test_corner_lo();
    test_corner_hi();
    test_back_to_back();
    test_reset_abort();
    test_px_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
